// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the control unit downstream of it.
//   - fetch FSM state encoding
//   - opcode field width and helpers that give its MSB/LSB in an instruction word
//   - default reset PC
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StFault = 2'd2
  } fetch_state_e;

  // The opcode is the top OPCODE_W bits of the instruction word.
  localparam int unsigned OPCODE_W = 4;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  function automatic int unsigned opcode_msb(input int unsigned data_w);
    return data_w - 1;
  endfunction

  function automatic int unsigned opcode_lsb(input int unsigned data_w);
    return data_w - OPCODE_W;
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Fetch timeout counter.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : zero the count (fetch accepted, REQ about to be entered)
//   en         : a REQ cycle without ack; the count advances
//   expired    : this enabled cycle brings the count to Limit
module fetch_timer #(
  parameter int unsigned Limit = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // The count never has to hold Limit itself: the cycle that would reach it
  // either takes an ack or leaves REQ for FAULT.
  localparam int unsigned CntW = (Limit > 1) ? $clog2(Limit) : 1;

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign expired = en && (cnt_q == CntW'(Limit - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds PC and IR, reads instruction words over a
// req/ack handshake and presents the opcode to the control unit.
//
// Optional feature: define FETCH_TIMEOUT_EN to add a REQ timeout that parks the
// unit in a sticky FAULT state (left only by reset). Without it REQ waits forever
// and fetch_fault is tied low.
//
// Ports:
//   clk, reset         : clock, asynchronous active-low reset
//   fetch              : strobe requesting the next instruction (accepted in IDLE)
//   pc_load, pc_target : branch target load (deferred to the ack while in REQ)
//   mem_req, mem_addr  : memory read request and address (address = PC)
//   mem_ack, mem_data  : read completion and instruction word
//   ir, opcode         : instruction register and its opcode field
//   ir_valid           : IR holds a completed fetch
//   busy               : fetch in progress
//   pc                 : current program counter
//   fetch_fault        : sticky fetch timeout
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 16,
  parameter int unsigned        DATA_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter int unsigned        TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] ir,
  output logic [3:0]        opcode,
  output logic              ir_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_fault
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  logic              ir_valid_q;
  logic              pend_valid_q;
  logic [ADDR_W-1:0] pend_target_q;
  logic              tmr_expired;

`ifdef FETCH_TIMEOUT_EN
  logic tmr_clr;
  logic tmr_en;

  assign tmr_clr = (state_q == StIdle) && fetch;
  assign tmr_en  = (state_q == StReq) && !mem_ack;

  fetch_timer #(
    .Limit (TIMEOUT)
  ) u_fetch_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );
`else
  assign tmr_expired = 1'b0;

  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      ir_q          <= '0;
      ir_valid_q    <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Load lands before the fetch starts, so the fetch reads pc_target.
          if (pc_load) begin
            pc_q <= pc_target;
          end
          if (fetch) begin
            state_q    <= StReq;
            ir_valid_q <= 1'b0;
          end
        end
        StReq: begin
          if (mem_ack) begin
            state_q      <= StIdle;
            ir_q         <= mem_data;
            ir_valid_q   <= 1'b1;
            pend_valid_q <= 1'b0;
            // A load in the ack cycle is the most recent pending load.
            if (pc_load) begin
              pc_q <= pc_target;
            end else if (pend_valid_q) begin
              pc_q <= pend_target_q;
            end else begin
              pc_q <= pc_q + ADDR_W'(1);
            end
          end else begin
            // PC must stay put while mem_addr is being presented.
            if (pc_load) begin
              pend_valid_q  <= 1'b1;
              pend_target_q <= pc_target;
            end
            if (tmr_expired) begin
              state_q <= StFault;
            end
          end
        end
        StFault: begin
          // Sticky until reset.
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mem_req  = (state_q == StReq);
  assign busy     = (state_q == StReq);
  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign opcode   = ir_q[opcode_msb(DATA_W):opcode_lsb(DATA_W)];

`ifdef FETCH_TIMEOUT_EN
  assign fetch_fault = (state_q == StFault);
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        fetch;
  logic        pc_load;
  logic [15:0] pc_target;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [15:0] ir;
  logic [3:0]  opcode;
  logic        ir_valid;
  logic        busy;
  logic [15:0] pc;
  logic        fetch_fault;

  int n_checks;
  int n_errors;

  fetch_unit #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .RESET_PC (16'h0000),
    .TIMEOUT  (15)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch       (fetch),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .ir          (ir),
    .opcode      (opcode),
    .ir_valid    (ir_valid),
    .busy        (busy),
    .pc          (pc),
    .fetch_fault (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are then driven and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    fetch     = 1'b0;
    pc_load   = 1'b0;
    pc_target = '0;
    mem_ack   = 1'b0;
    mem_data  = '0;
    tick();
    tick();

    // Reset state
    check_eq("rst_pc", pc, 16'h0000);
    check_eq("rst_ir", ir, 16'h0000);
    check_eq("rst_opcode", opcode, 4'h0);
    check_eq("rst_ir_valid", ir_valid, 1'b0);
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_fault", fetch_fault, 1'b0);
    reset = 1'b1;
    tick();

    // Minimum-latency fetch
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    check_eq("t1_mem_req", mem_req, 1'b1);
    check_eq("t1_busy", busy, 1'b1);
    check_eq("t1_mem_addr", mem_addr, 16'h0000);
    mem_ack  = 1'b1;
    mem_data = 16'h1ABC;
    tick();
    mem_ack = 1'b0;
    check_eq("t1_ir", ir, 16'h1ABC);
    check_eq("t1_opcode", opcode, 4'b0001);
    check_eq("t1_pc", pc, 16'h0001);
    check_eq("t1_ir_valid", ir_valid, 1'b1);
    check_eq("t1_mem_req_done", mem_req, 1'b0);

    // Delayed ack; stray fetch in REQ must be ignored
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    check_eq("t2_ir_valid_clr", ir_valid, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check_eq("t2_mem_req_hold", mem_req, 1'b1);
      check_eq("t2_mem_addr_hold", mem_addr, 16'h0001);
      if (i == 2) fetch = 1'b1;
      if (i == 5) begin
        mem_ack  = 1'b1;
        mem_data = 16'h2345;
      end
      tick();
      fetch = 1'b0;
    end
    mem_ack = 1'b0;
    check_eq("t2_ir", ir, 16'h2345);
    check_eq("t2_pc", pc, 16'h0002);
    check_eq("t2_mem_req_done", mem_req, 1'b0);
    tick();
    check_eq("t2_single_read", mem_req, 1'b0);

    // Load and fetch in the same cycle
    pc_load   = 1'b1;
    pc_target = 16'h0040;
    fetch     = 1'b1;
    tick();
    pc_load = 1'b0;
    fetch   = 1'b0;
    check_eq("t3_mem_addr", mem_addr, 16'h0040);
    mem_ack  = 1'b1;
    mem_data = 16'h3000;
    tick();
    mem_ack = 1'b0;
    check_eq("t3_pc", pc, 16'h0041);
    check_eq("t3_opcode", opcode, 4'h3);

    // Two loads during REQ, last wins, no increment
    fetch = 1'b1;
    tick();
    fetch     = 1'b0;
    pc_load   = 1'b1;
    pc_target = 16'h0100;
    tick();
    pc_target = 16'h0200;
    tick();
    pc_load = 1'b0;
    check_eq("t4_pc_frozen", pc, 16'h0041);
    check_eq("t4_addr_frozen", mem_addr, 16'h0041);
    mem_ack  = 1'b1;
    mem_data = 16'h4111;
    tick();
    mem_ack = 1'b0;
    check_eq("t4_pc_target", pc, 16'h0200);
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    check_eq("t4_next_addr", mem_addr, 16'h0200);
    mem_ack  = 1'b1;
    mem_data = 16'h5222;
    tick();
    mem_ack = 1'b0;
    check_eq("t4_next_pc", pc, 16'h0201);

    // Load in the ack cycle counts as pending
    fetch = 1'b1;
    tick();
    fetch     = 1'b0;
    mem_ack   = 1'b1;
    mem_data  = 16'h6333;
    pc_load   = 1'b1;
    pc_target = 16'h0300;
    tick();
    mem_ack = 1'b0;
    pc_load = 1'b0;
    check_eq("t5_ack_load_pc", pc, 16'h0300);

    // Idle load keeps IR; ack outside REQ ignored; PC wraps
    pc_load   = 1'b1;
    pc_target = 16'hFFFF;
    mem_ack   = 1'b1;
    mem_data  = 16'hFFFF;
    tick();
    pc_load = 1'b0;
    mem_ack = 1'b0;
    check_eq("t6_idle_load", pc, 16'hFFFF);
    check_eq("t6_ir_kept", ir, 16'h6333);
    check_eq("t6_ir_valid_kept", ir_valid, 1'b1);
    check_eq("t6_no_req", mem_req, 1'b0);
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    check_eq("t6_addr", mem_addr, 16'hFFFF);
    mem_ack  = 1'b1;
    mem_data = 16'h7444;
    tick();
    mem_ack = 1'b0;
    check_eq("t6_wrap", pc, 16'h0000);

    // Asynchronous reset mid-fetch
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    check_eq("t7_req", mem_req, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t7_async_drop", mem_req, 1'b0);
    check_eq("t7_ir_clr", ir, 16'h0000);
    tick();
    reset = 1'b1;
    tick();
    check_eq("t7_pc", pc, 16'h0000);
    check_eq("t7_still_idle", mem_req, 1'b0);

`ifdef FETCH_TIMEOUT_EN
    // Ack on the last allowed cycle wins
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check_eq("t8_req_last", mem_req, 1'b1);
    mem_ack  = 1'b1;
    mem_data = 16'h8555;
    tick();
    mem_ack = 1'b0;
    check_eq("t8_ack_wins_fault", fetch_fault, 1'b0);
    check_eq("t8_ack_wins_ir", ir, 16'h8555);

    // Timeout into FAULT
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check_eq("t9_req_14", mem_req, 1'b1);
    check_eq("t9_no_fault_yet", fetch_fault, 1'b0);
    tick();
    check_eq("t9_fault", fetch_fault, 1'b1);
    check_eq("t9_req_drop", mem_req, 1'b0);
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    tick();
    check_eq("t9_fetch_ignored", mem_req, 1'b0);
    check_eq("t9_fault_sticky", fetch_fault, 1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check_eq("t9_fault_cleared", fetch_fault, 1'b0);
    check_eq("t9_pc_reset", pc, 16'h0000);
`else
    // No timeout: REQ waits forever without raising a fault
    begin
      int fault_cycles;
      fault_cycles = 0;
      fetch = 1'b1;
      tick();
      fetch = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (fetch_fault !== 1'b0) fault_cycles++;
        tick();
      end
      check_eq("t9_no_fault", fault_cycles, 0);
      check_eq("t9_still_req", mem_req, 1'b1);
      mem_ack  = 1'b1;
      mem_data = 16'h9666;
      tick();
      mem_ack = 1'b0;
      check_eq("t9_late_ack_pc", pc, 16'h0001);
      check_eq("t9_late_ack_ir", ir, 16'h9666);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of `control_unit`. Holds the program counter (PC) and instruction register (IR), reads instruction words from memory over a req/ack handshake, and presents `opcode` to the control unit. A fetch starts on a strobe from the control unit, and branch targets are loaded from the datapath.

## Interface
- `ADDR_W`, 16: PC and memory address width.
- `DATA_W`, 16: instruction word width; must be ≥ 4.
- `RESET_PC`, 16'h0000: PC value after reset.
- `TIMEOUT`, 15: fetch timeout limit in REQ cycles without ack. Used only with `FETCH_TIMEOUT_EN`.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (one clock domain; polarity and async fixed).
- `fetch`  in  1  single-cycle strobe from the control unit requesting the next instruction.
- `pc_load`  in  1  load the branch target into the PC.
- `pc_target`  in  ADDR_W  branch target address.
- `mem_req`  out  1  memory read request.
- `mem_addr`  out  ADDR_W  read address; equals PC while `mem_req`=1.
- `mem_ack`  in  1  memory read complete; `mem_data` is valid in the same cycle.
- `mem_data`  in  DATA_W  instruction word from memory.
- `ir`  out  DATA_W  instruction register.
- `opcode`  out  4  `ir[DATA_W-1:DATA_W-4]`, fed to the control unit.
- `ir_valid`  out  1  IR holds a completed fetch.
- `busy`  out  1  high in state REQ.
- `pc`  out  ADDR_W  current PC.
- `fetch_fault`  out  1  sticky fetch timeout; goes to the control unit's fault logic.

## Operation
- FSM states: IDLE, REQ, FAULT.
- IDLE:
  - `fetch`=1 → REQ, and `ir_valid` clears.
  - `pc_load`=1 → PC takes `pc_target`.
  - Both in the same cycle: the load applies first, so the fetch reads `pc_target`.
- REQ:
  - `mem_req`=1 and `mem_addr`=PC.
  - On a cycle with `mem_ack`=1: IR takes `mem_data`, `ir_valid` takes 1, state → IDLE.
  - On the same ack, PC takes PC+1 modulo 2^ADDR_W (0xFFFF wraps to 0x0000), unless a load is pending (see below).
- Pending load:
  - `pc_load` during REQ stores `pc_target` into a pending register; the PC does not change during REQ.
  - On ack, PC takes the pending target instead of PC+1, and the pending register clears.
  - Several loads during one REQ: the last one wins.
  - A load in the ack cycle itself counts as pending for that ack.
- Ignored inputs: `fetch` in REQ or FAULT; `mem_ack` outside REQ.
- FAULT (with macro only):
  - `mem_req`=0, `fetch_fault`=1, and all inputs are ignored.
  - Exit only by reset.
- IR and `ir_valid` keep their values in IDLE when no fetch is accepted.

## Timing
- Reset values: state IDLE, PC=`RESET_PC`, IR=0, `opcode`=0, `ir_valid`=0, `mem_req`=0, `busy`=0, `fetch_fault`=0, pending load cleared.
- Reset asserted mid-fetch: `mem_req` drops immediately (asynchronously) and the fetch is abandoned.
- Fetch sequence:
  - `fetch` sampled at edge E0 → `mem_req`=1 after E0.
  - `mem_ack` sampled at edge E1 → IR, PC and `ir_valid` update after E1, and `mem_req`=0 after E1.
- Minimum latency is 2 edges (ack in the first REQ cycle). A new fetch may be accepted on the edge after E1.
- `mem_addr` is stable for the whole REQ period.
- All outputs are registered or decode from registers only. No combinational path from inputs to outputs.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A cycle counter is cleared on entry to REQ and increments on each REQ cycle without ack.
  - When the count reaches `TIMEOUT` with no ack, the next edge goes to FAULT.
  - An ack in the same cycle the count reaches `TIMEOUT` wins; no fault is raised.
- Not defined:
  - No counter and no FAULT state; REQ waits indefinitely.
  - `fetch_fault` is tied to 0.

## Structure
- Shared package / `controlSignal.v` defines: FSM state encodings, the opcode field MSB/LSB position constants, and `RESET_PC`. The control unit uses the same opcode constants.
- One sub-module, `fetch_timer`: the timeout counter with clear, enable and expired signals. It is instantiated only under `FETCH_TIMEOUT_EN`.

## Test plan
- Reset then `fetch`; ack in the first REQ cycle with `mem_data`=16'h1ABC → `mem_addr`=0x0000, `ir`=0x1ABC, `opcode`=4'b0001, `pc`=0x0001, `ir_valid`=1 two edges after the fetch.
- `fetch` with `mem_ack` delayed 5 cycles → `mem_req` and `mem_addr` held stable 6 cycles; a second `fetch` pulse during REQ is ignored (exactly one memory read).
- `pc_load` with `pc_target`=0x0040 in the same cycle as `fetch` → `mem_addr`=0x0040, `pc`=0x0041 after ack.
- `pc_load` with 0x0100, then 0x0200, during REQ → after ack `pc`=0x0200 (no increment); the next fetch reads 0x0200.
- PC=0xFFFF, fetch and ack → `pc`=0x0000.
- `FETCH_TIMEOUT_EN`, `TIMEOUT`=15, no ack → `fetch_fault`=1 and `mem_req`=0 after 15 REQ cycles, and `fetch` is ignored afterwards. A `reset` pulse returns PC=`RESET_PC` and `fetch_fault`=0. Without the macro, the bench checks `fetch_fault` stays 0 for 100 cycles.
